mem_access_unit: RTL

- Datapath stage directly downstream of the effective-address block.
- Consumes the 16-bit effective address and runs the LC-3 memory transaction for LD/ST/LDI/STI through MAR/MDR, using a req/ack handshake to data memory.
- Returns load data to the register-file write path and reports completion to the control FSM.

---
 rtl/mem_access_unit.sv | 131 +++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// LC-3 memory stage: drives MAR/MDR through a req/ack handshake for LD/ST/LDI/STI.
// Define MEM_TIMEOUT_EN to bound the ack wait and report err together with done.
module mem_access_unit #(
    parameter int ADDR_W         = 16,
    parameter int DATA_W         = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [ADDR_W-1:0] eab_addr,
    input  logic [DATA_W-1:0] store_data,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] load_data,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_IND,
        S_GAP,
        S_ACC,
        S_DONE
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] mar_q, mar_d;
    logic [DATA_W-1:0] mdr_q, mdr_d;
    logic [1:0]        op_q, op_d;
    logic              tmo;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

`ifdef MEM_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q;

    // Counter is zero whenever req is low, so entry to IND/ACC starts from 0.
    assign cnt_d = (mem_req && !mem_ack) ? cnt_q + 1'b1 : '0;
    assign tmo   = mem_req && !mem_ack && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= tmo;
        end
    end

    assign err = err_q;
`else
    assign tmo = 1'b0;
    assign err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            mar_q   <= '0;
            mdr_q   <= '0;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            mar_q   <= mar_d;
            mdr_q   <= mdr_d;
            op_q    <= op_d;
        end
    end

    always_comb begin
        state_d = state_q;
        mar_d   = mar_q;
        mdr_d   = mdr_q;
        op_d    = op_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    mar_d = eab_addr;
                    op_d  = op;
                    if (op[0]) mdr_d = store_data;
                    state_d = op[1] ? S_IND : S_ACC;
                end
            end
            S_IND: begin
                if (mem_ack) begin
                    mar_d   = ADDR_W'(mem_rdata);
                    state_d = S_GAP;
                end else if (tmo) begin
                    state_d = S_DONE;
                end
            end
            S_GAP: state_d = S_ACC;
            S_ACC: begin
                if (mem_ack) begin
                    if (!op_q[0]) mdr_d = mem_rdata;
                    state_d = S_DONE;
                end else if (tmo) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy    = (state_q != S_IDLE);
        done    = (state_q == S_DONE);
        mem_req = (state_q == S_IND) || (state_q == S_ACC);
        mem_we  = (state_q == S_ACC) && op_q[0];
    end

    assign mem_addr  = mar_q;
    assign mem_wdata = mdr_q;
    assign load_data = mdr_q;

endmodule
